// File: rtl/out_arb_mux_if.sv
// rtl/out_arb_mux_if.sv - flit input ports, registered output flit and grant for the output arbiter mux
interface out_arb_mux_if #(
    parameter int PORT_N = 5,
    parameter int DATA_W = 32,
    parameter int VCH_W  = 2
);
    logic [PORT_N-1:0]             in_valid;
    logic [PORT_N-1:0][DATA_W-1:0] in_data;
    logic [PORT_N-1:0][VCH_W-1:0]  in_vch;
    logic [PORT_N-1:0]             in_head;
    logic [PORT_N-1:0]             in_tail;
    logic [PORT_N-1:0]             in_ready;
    logic                          out_valid;
    logic [DATA_W-1:0]             out_data;
    logic [VCH_W-1:0]              out_vch;
    logic                          out_tail;
    logic                          out_ready;
    logic [PORT_N-1:0]             grant;

    modport master (
        output in_valid, in_data, in_vch, in_head, in_tail, out_ready,
        input  in_ready, out_valid, out_data, out_vch, out_tail, grant
    );

    modport slave (
        input  in_valid, in_data, in_vch, in_head, in_tail, out_ready,
        output in_ready, out_valid, out_data, out_vch, out_tail, grant
    );
endinterface

// File: rtl/out_arb_mux.sv
// rtl/out_arb_mux.sv - round-robin output arbiter with optional wormhole packet lock and a one-flit output register
module out_arb_mux #(
    parameter int PORT_N   = 5,
    parameter int DATA_W   = 32,
    parameter int VCH_W    = 2,
    parameter int LOCK_PKT = 1
) (
    input logic         clk,
    input logic         rst,
    out_arb_mux_if.slave bus
);
    localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [VCH_W-1:0]   out_vch_q;
    logic               out_tail_q;

    logic [PORT_N-1:0]  cand;
    logic [PORT_N-1:0]  grant;
    logic [PORT_N-1:0]  ready;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   sel;
    logic               found;
    logic               load_en;
    logic               accept;
    int                 idx;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        return (32'(v) == PORT_N - 1) ? '0 : v + 1'b1;
    endfunction

    // Cyclic first-candidate search starting at ptr_q.
    always_comb begin
        cand  = (LOCK_PKT != 0) ? (bus.in_valid & bus.in_head) : bus.in_valid;
        found = 1'b0;
        gidx  = ptr_q;
        idx   = 0;
        for (int k = 0; k < PORT_N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= PORT_N) begin
                idx = idx - PORT_N;
            end
            if (!found && cand[idx]) begin
                found = 1'b1;
                gidx  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (rst) begin
            grant = '0;
        end else if (state_q == LOCKED) begin
            grant[owner_q] = 1'b1;
        end else if (found) begin
            grant[gidx] = 1'b1;
        end
        sel     = (state_q == LOCKED) ? owner_q : gidx;
        load_en = !out_valid_q || bus.out_ready;
        ready   = grant & {PORT_N{load_en}};
        accept  = |(ready & bus.in_valid);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((LOCK_PKT != 0) && bus.in_head[sel] && !bus.in_tail[sel]) begin
                        state_d = LOCKED;
                        owner_d = sel;
                    end else begin
                        ptr_d = wrap_inc(sel);
                    end
                end
            end
            LOCKED: begin
                // Re-arbitration waits for the cycle after the tail leaves.
                if (accept && bus.in_tail[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vch_q   <= '0;
            out_tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            if (load_en) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q <= bus.in_data[sel];
                    out_vch_q  <= bus.in_vch[sel];
                    out_tail_q <= bus.in_tail[sel];
                end
            end
        end
    end

    assign bus.grant     = grant;
    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_vch   = out_vch_q;
    assign bus.out_tail  = out_tail_q;
endmodule

// File: tb/tb_out_arb_mux.sv
// tb/tb_out_arb_mux.sv - directed and scoreboarded checks of out_arb_mux in lock and per-flit modes
module tb_out_arb_mux;
    localparam int PN = 5;
    localparam int DW = 32;
    localparam int VW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    out_arb_mux_if #(.PORT_N(PN), .DATA_W(DW), .VCH_W(VW)) bus_a ();
    out_arb_mux_if #(.PORT_N(PN), .DATA_W(DW), .VCH_W(VW)) bus_b ();

    out_arb_mux #(.PORT_N(PN), .DATA_W(DW), .VCH_W(VW), .LOCK_PKT(1)) u_lock (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    out_arb_mux #(.PORT_N(PN), .DATA_W(DW), .VCH_W(VW), .LOCK_PKT(0)) u_flit (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_a();
        bus_a.in_valid  = '0;
        bus_a.in_head   = '0;
        bus_a.in_tail   = '0;
        bus_a.in_data   = '0;
        bus_a.in_vch    = '0;
        bus_a.out_ready = 1'b1;
    endtask

    task automatic idle_b();
        bus_b.in_valid  = '0;
        bus_b.in_head   = '0;
        bus_b.in_tail   = '0;
        bus_b.in_data   = '0;
        bus_b.in_vch    = '0;
        bus_b.out_ready = 1'b1;
    endtask

    int             tx_seq[PN];
    int             rx_seq[PN];
    int             idx_p[PN];
    int             len_p[PN];
    logic [PN-1:0]  pend;
    logic [PN-1:0]  xfer;
    int             cur_lock;
    int             port;
    int             delivered;
    logic [PN-1:0]  exp_b[7];

    initial begin
        rst = 1'b1;
        idle_a();
        idle_b();
        bus_a.in_valid   = 5'b10100;
        bus_a.in_head    = 5'b10100;
        bus_a.in_tail    = 5'b10100;
        bus_a.in_data[2] = 32'hA2;
        bus_a.in_vch[2]  = 2'd2;
        bus_a.in_data[4] = 32'hA4;
        bus_a.in_vch[4]  = 2'd1;
        mid();
        check("rst_grant", 64'(bus_a.grant), 0);
        check("rst_in_ready", 64'(bus_a.in_ready), 0);
        tick();
        mid();
        check("rst_out_valid", 64'(bus_a.out_valid), 0);
        check("rst_out_data", 64'(bus_a.out_data), 0);
        check("rst_ptr", 64'(u_lock.ptr_q), 0);

        // Two single-flit packets on ports 2 and 4
        tick();
        rst = 1'b0;
        mid();
        check("sf_grant_p2", 64'(bus_a.grant), 64'b00100);
        check("sf_ready_p2", 64'(bus_a.in_ready), 64'b00100);
        tick();
        bus_a.in_valid = 5'b10000;
        mid();
        check("sf_grant_p4", 64'(bus_a.grant), 64'b10000);
        check("sf_out_valid1", 64'(bus_a.out_valid), 1);
        check("sf_out_data_p2", 64'(bus_a.out_data), 64'hA2);
        check("sf_out_vch_p2", 64'(bus_a.out_vch), 2);
        tick();
        bus_a.in_valid = '0;
        mid();
        check("sf_out_data_p4", 64'(bus_a.out_data), 64'hA4);
        check("sf_grant_none", 64'(bus_a.grant), 0);
        tick();
        mid();
        check("sf_drained", 64'(bus_a.out_valid), 0);
        check("sf_ptr_wrap", 64'(u_lock.ptr_q), 0);

        // Port 1 three-flit packet while port 3 holds a head
        tick();
        bus_a.in_valid   = 5'b01010;
        bus_a.in_head    = 5'b01010;
        bus_a.in_tail    = 5'b01000;
        bus_a.in_data[1] = 32'hB0;
        bus_a.in_data[3] = 32'hC3;
        mid();
        check("lk_head_grant", 64'(bus_a.grant), 64'b00010);
        tick();
        bus_a.in_head[1] = 1'b0;
        bus_a.in_data[1] = 32'hB1;
        mid();
        check("lk_body_grant", 64'(bus_a.grant), 64'b00010);
        check("lk_body_ready", 64'(bus_a.in_ready), 64'b00010);
        check("lk_out_head", 64'(bus_a.out_data), 64'hB0);
        tick();
        bus_a.in_valid[1] = 1'b0;
        mid();
        check("lk_bubble_grant", 64'(bus_a.grant), 64'b00010);
        check("lk_out_body", 64'(bus_a.out_data), 64'hB1);
        tick();
        bus_a.in_valid[1] = 1'b1;
        bus_a.in_tail[1]  = 1'b1;
        bus_a.in_data[1]  = 32'hB2;
        mid();
        check("lk_tail_grant", 64'(bus_a.grant), 64'b00010);
        check("lk_bubble_empty", 64'(bus_a.out_valid), 0);
        tick();
        bus_a.in_valid[1] = 1'b0;
        mid();
        check("lk_ptr_after_tail", 64'(u_lock.ptr_q), 2);
        check("lk_p3_granted", 64'(bus_a.grant), 64'b01000);
        check("lk_out_tail_data", 64'(bus_a.out_data), 64'hB2);
        check("lk_out_tail_flag", 64'(bus_a.out_tail), 1);
        tick();
        bus_a.in_valid[3] = 1'b0;
        mid();
        check("lk_out_p3", 64'(bus_a.out_data), 64'hC3);
        check("lk_ptr_p3", 64'(u_lock.ptr_q), 4);

        // Back-pressure: out_ready low for 4 cycles
        tick();
        bus_a.in_valid   = 5'b00101;
        bus_a.in_head    = 5'b00101;
        bus_a.in_tail    = 5'b00101;
        bus_a.in_data[0] = 32'hD0;
        bus_a.in_data[2] = 32'hD2;
        mid();
        check("bp_grant_wrap", 64'(bus_a.grant), 64'b00001);
        tick();
        bus_a.in_valid[0] = 1'b0;
        bus_a.out_ready   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("bp_stable_data", 64'(bus_a.out_data), 64'hD0);
            check("bp_stable_valid", 64'(bus_a.out_valid), 1);
            check("bp_no_ready", 64'(bus_a.in_ready), 0);
            check("bp_grant_held", 64'(bus_a.grant), 64'b00100);
            tick();
        end
        bus_a.out_ready = 1'b1;
        mid();
        check("bp_release_ready", 64'(bus_a.in_ready), 64'b00100);
        tick();
        bus_a.in_valid = '0;
        mid();
        check("bp_next_flit", 64'(bus_a.out_data), 64'hD2);
        tick();

        // Random packets against a scoreboard
        idle_a();
        pend      = '0;
        cur_lock  = -1;
        delivered = 0;
        for (int p = 0; p < PN; p++) begin
            tx_seq[p] = 0;
            rx_seq[p] = 0;
            idx_p[p]  = 0;
            len_p[p]  = 1;
        end
        xfer = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < PN; p++) begin
                if (pend[p] && xfer[p]) begin
                    pend[p] = 1'b0;
                    tx_seq[p]++;
                    idx_p[p]++;
                    if (idx_p[p] == len_p[p]) idx_p[p] = 0;
                end
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    if (idx_p[p] == 0) len_p[p] = int'($urandom_range(1, 3));
                end
                bus_a.in_valid[p] = pend[p];
                bus_a.in_data[p]  = {4'(p), 28'(tx_seq[p])};
                bus_a.in_vch[p]   = 2'(p);
                bus_a.in_head[p]  = (idx_p[p] == 0);
                bus_a.in_tail[p]  = (idx_p[p] == len_p[p] - 1);
            end
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            mid();
            check("rnd_ready_onehot", 64'($onehot0(bus_a.in_ready)), 1);
            check("rnd_ready_granted", 64'(bus_a.in_ready & ~bus_a.grant), 0);
            xfer = bus_a.in_valid & bus_a.in_ready;
            if (bus_a.out_valid && bus_a.out_ready) begin
                port = int'(bus_a.out_data[31:28]);
                if (port < PN) begin
                    check("rnd_order", 64'(bus_a.out_data[27:0]), 64'(28'(rx_seq[port])));
                    rx_seq[port]++;
                end else begin
                    check("rnd_port_range", 64'(port), 0);
                end
                if (cur_lock >= 0) check("rnd_contig", 64'(port), 64'(cur_lock));
                cur_lock = bus_a.out_tail ? -1 : port;
                delivered++;
            end
            tick();
        end
        check("rnd_delivered", 64'(delivered > 100), 1);

        // Reset taken mid-packet
        rst = 1'b1;
        idle_a();
        tick();
        tick();
        rst = 1'b0;
        bus_a.in_valid   = 5'b00100;
        bus_a.in_head    = 5'b00100;
        bus_a.in_data[2] = 32'hE0;
        mid();
        check("mr_head_grant", 64'(bus_a.grant), 64'b00100);
        tick();
        rst = 1'b1;
        bus_a.in_head    = '0;
        bus_a.in_data[2] = 32'hE1;
        mid();
        check("mr_rst_grant", 64'(bus_a.grant), 0);
        check("mr_rst_ready", 64'(bus_a.in_ready), 0);
        tick();
        rst = 1'b0;
        mid();
        check("mr_out_valid", 64'(bus_a.out_valid), 0);
        check("mr_grant", 64'(bus_a.grant), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            mid();
            check("mr_body_stalled", 64'(bus_a.in_ready), 0);
        end
        tick();
        idle_a();

        // Per-flit mode round robin over ports 0, 1, 4
        exp_b = '{5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000, 5'b00001};
        bus_b.in_valid = 5'b10011;
        for (int p = 0; p < PN; p++) bus_b.in_data[p] = 32'hF0 + p;
        for (int i = 0; i < 7; i++) begin
            mid();
            check("fl_grant", 64'(bus_b.grant), 64'(exp_b[i]));
            if (i > 0) begin
                check("fl_out_valid", 64'(bus_b.out_valid), 1);
                check("fl_out_data", 64'(bus_b.out_data), 64'(32'hF0 + $clog2(exp_b[i-1])));
            end
            if (i == 3) check("fl_ptr_wrap", 64'(u_flit.ptr_q), 0);
            tick();
        end
        idle_b();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
